// File: rtl/punc_ctrl_pkg.sv
// PUnC LC3 control encodings shared by the controller and datapath.
// States, opcodes and every mux-select / ALU encoding live here.
package punc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_EXEC2  = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RES  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic PC_DATA_ADDER = 1'b0;
   localparam logic PC_DATA_BASER = 1'b1;

   localparam logic PC_ADD_OFF11 = 1'b0;
   localparam logic PC_ADD_OFF9  = 1'b1;

   localparam logic [1:0] MEM_ADDR_PC    = 2'b00;
   localparam logic [1:0] MEM_ADDR_ALU   = 2'b01;
   localparam logic [1:0] MEM_ADDR_STORE = 2'b10;

   localparam logic [1:0] RF_W_PC  = 2'b00;
   localparam logic [1:0] RF_W_MEM = 2'b01;
   localparam logic [1:0] RF_W_ALU = 2'b10;

   localparam logic [1:0] SEXT_IMM5  = 2'b00;
   localparam logic [1:0] SEXT_OFF6  = 2'b01;
   localparam logic [1:0] SEXT_OFF9  = 2'b10;
   localparam logic [1:0] SEXT_OFF11 = 2'b11;

   localparam logic ALU_A_PC = 1'b0;
   localparam logic ALU_A_RF = 1'b1;

   localparam logic ALU_B_RF   = 1'b0;
   localparam logic ALU_B_SEXT = 1'b1;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_AND  = 2'b01;
   localparam logic [1:0] ALU_NOT  = 2'b10;
   localparam logic [1:0] ALU_PASS = 2'b11;

   localparam logic NZP_ALU = 1'b0;
   localparam logic NZP_MEM = 1'b1;

   localparam logic [2:0] REG_R7 = 3'd7;

endpackage

// File: rtl/punc_control_if.sv
// Control bundle between the PUnC controller (master) and datapath (slave).
// Carries IR/flags toward the controller and all selects/enables back.
interface punc_control_if;

   logic [15:0] ir;
   logic        cc_n;
   logic        cc_z;
   logic        cc_p;

   logic        pc_clr;
   logic        pc_inc;
   logic        pc_ld;
   logic        pc_data_sel;
   logic        pc_add_sel;
   logic        ir_ld;
   logic [1:0]  mem_addr_sel;
   logic        mem_w_en;
   logic        store_ld;
   logic [2:0]  rf_r_addr_0;
   logic [2:0]  rf_r_addr_1;
   logic [2:0]  rf_w_addr;
   logic        rf_w_en;
   logic [1:0]  rf_w_sel;
   logic [1:0]  sext_sel;
   logic        alu_a_sel;
   logic        alu_b_sel;
   logic [1:0]  alu_op;
   logic        nzp_sel;
   logic        nzp_ld;
   logic        halted;

   modport master (
      input  ir, cc_n, cc_z, cc_p,
      output pc_clr, pc_inc, pc_ld, pc_data_sel, pc_add_sel,
      output ir_ld, mem_addr_sel, mem_w_en, store_ld,
      output rf_r_addr_0, rf_r_addr_1, rf_w_addr, rf_w_en, rf_w_sel,
      output sext_sel, alu_a_sel, alu_b_sel, alu_op,
      output nzp_sel, nzp_ld, halted
   );

   modport slave (
      output ir, cc_n, cc_z, cc_p,
      input  pc_clr, pc_inc, pc_ld, pc_data_sel, pc_add_sel,
      input  ir_ld, mem_addr_sel, mem_w_en, store_ld,
      input  rf_r_addr_0, rf_r_addr_1, rf_w_addr, rf_w_en, rf_w_sel,
      input  sext_sel, alu_a_sel, alu_b_sel, alu_op,
      input  nzp_sel, nzp_ld, halted
   );

endinterface

// File: rtl/punc_control_br_eval.sv
// Branch-taken evaluation: any requested flag that is currently set.
// nzp=000 in the instruction therefore never branches.
module punc_br_eval (
   input  logic [2:0] i_nzp,
   input  logic       i_cc_n,
   input  logic       i_cc_z,
   input  logic       i_cc_p,
   output logic       o_taken
);

   assign o_taken = (i_nzp[2] & i_cc_n)
                  | (i_nzp[1] & i_cc_z)
                  | (i_nzp[0] & i_cc_p);

endmodule

// File: rtl/punc_control.sv
// PUnC multicycle controller: FETCH/DECODE/EXEC[/EXEC2] per instruction.
// Outputs are purely combinational from state, IR and condition flags.
module punc_control
   import punc_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   punc_control_if.master bus
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] w_op;
   logic       w_taken;
   logic       w_unused;

   assign w_op     = bus.ir[15:12];
   assign w_unused = ^bus.ir[4:3];

   punc_br_eval u_br (
      .i_nzp   (bus.ir[11:9]),
      .i_cc_n  (bus.cc_n),
      .i_cc_z  (bus.cc_z),
      .i_cc_p  (bus.cc_p),
      .o_taken (w_taken)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next           = r_state;
      bus.pc_clr       = 1'b0;
      bus.pc_inc       = 1'b0;
      bus.pc_ld        = 1'b0;
      bus.pc_data_sel  = PC_DATA_ADDER;
      bus.pc_add_sel   = PC_ADD_OFF11;
      bus.ir_ld        = 1'b0;
      bus.mem_addr_sel = MEM_ADDR_PC;
      bus.mem_w_en     = 1'b0;
      bus.store_ld     = 1'b0;
      bus.rf_r_addr_0  = 3'd0;
      bus.rf_r_addr_1  = 3'd0;
      bus.rf_w_addr    = 3'd0;
      bus.rf_w_en      = 1'b0;
      bus.rf_w_sel     = RF_W_PC;
      bus.sext_sel     = SEXT_IMM5;
      bus.alu_a_sel    = ALU_A_PC;
      bus.alu_b_sel    = ALU_B_RF;
      bus.alu_op       = ALU_ADD;
      bus.nzp_sel      = NZP_ALU;
      bus.nzp_ld       = 1'b0;
      bus.halted       = 1'b0;

      // reset masks every enable, even mid-EXEC2 of a store
      if (rst) begin
         bus.pc_clr = 1'b1;
      end else begin
         unique case (r_state)
            S_FETCH: begin
               bus.mem_addr_sel = MEM_ADDR_PC;
               bus.ir_ld        = 1'b1;
               bus.pc_inc       = 1'b1;
               w_next           = S_DECODE;
            end
            S_DECODE: begin
               w_next = (w_op == OP_TRAP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
               w_next = S_FETCH;
               case (w_op)
                  OP_ADD, OP_AND: begin
                     bus.rf_r_addr_0 = bus.ir[8:6];
                     bus.rf_r_addr_1 = bus.ir[2:0];
                     bus.alu_a_sel   = ALU_A_RF;
                     bus.alu_b_sel   = bus.ir[5];
                     bus.sext_sel    = SEXT_IMM5;
                     bus.alu_op      = (w_op == OP_AND) ? ALU_AND : ALU_ADD;
                     bus.rf_w_sel    = RF_W_ALU;
                     bus.rf_w_addr   = bus.ir[11:9];
                     bus.rf_w_en     = 1'b1;
                     bus.nzp_sel     = NZP_ALU;
                     bus.nzp_ld      = 1'b1;
                  end
                  OP_NOT: begin
                     bus.rf_r_addr_0 = bus.ir[8:6];
                     bus.alu_a_sel   = ALU_A_RF;
                     bus.alu_op      = ALU_NOT;
                     bus.rf_w_sel    = RF_W_ALU;
                     bus.rf_w_addr   = bus.ir[11:9];
                     bus.rf_w_en     = 1'b1;
                     bus.nzp_sel     = NZP_ALU;
                     bus.nzp_ld      = 1'b1;
                  end
                  OP_BR: begin
                     if (w_taken) begin
                        bus.pc_ld       = 1'b1;
                        bus.pc_data_sel = PC_DATA_ADDER;
                        bus.pc_add_sel  = PC_ADD_OFF9;
                     end
                  end
                  OP_JMP: begin
                     bus.rf_r_addr_0 = bus.ir[8:6];
                     bus.pc_ld       = 1'b1;
                     bus.pc_data_sel = PC_DATA_BASER;
                  end
                  OP_JSR: begin
                     // link write and base read share a cycle; read sees old R7
                     bus.rf_w_en   = 1'b1;
                     bus.rf_w_addr = REG_R7;
                     bus.rf_w_sel  = RF_W_PC;
                     bus.pc_ld     = 1'b1;
                     if (bus.ir[11]) begin
                        bus.pc_data_sel = PC_DATA_ADDER;
                        bus.pc_add_sel  = PC_ADD_OFF11;
                     end else begin
                        bus.pc_data_sel = PC_DATA_BASER;
                        bus.rf_r_addr_0 = bus.ir[8:6];
                     end
                  end
                  OP_LD, OP_LDR: begin
                     bus.rf_r_addr_0  = bus.ir[8:6];
                     bus.alu_a_sel    = (w_op == OP_LDR) ? ALU_A_RF : ALU_A_PC;
                     bus.alu_b_sel    = ALU_B_SEXT;
                     bus.sext_sel     = (w_op == OP_LDR) ? SEXT_OFF6 : SEXT_OFF9;
                     bus.alu_op       = ALU_ADD;
                     bus.mem_addr_sel = MEM_ADDR_ALU;
                     bus.rf_w_sel     = RF_W_MEM;
                     bus.rf_w_addr    = bus.ir[11:9];
                     bus.rf_w_en      = 1'b1;
                     bus.nzp_sel      = NZP_MEM;
                     bus.nzp_ld       = 1'b1;
                  end
                  OP_ST, OP_STR: begin
                     bus.rf_r_addr_0  = bus.ir[8:6];
                     bus.rf_r_addr_1  = bus.ir[11:9];
                     bus.alu_a_sel    = (w_op == OP_STR) ? ALU_A_RF : ALU_A_PC;
                     bus.alu_b_sel    = ALU_B_SEXT;
                     bus.sext_sel     = (w_op == OP_STR) ? SEXT_OFF6 : SEXT_OFF9;
                     bus.alu_op       = ALU_ADD;
                     bus.mem_addr_sel = MEM_ADDR_ALU;
                     bus.mem_w_en     = 1'b1;
                  end
                  OP_LEA: begin
                     bus.alu_a_sel = ALU_A_PC;
                     bus.alu_b_sel = ALU_B_SEXT;
                     bus.sext_sel  = SEXT_OFF9;
                     bus.alu_op    = ALU_ADD;
                     bus.rf_w_sel  = RF_W_ALU;
                     bus.rf_w_addr = bus.ir[11:9];
                     bus.rf_w_en   = 1'b1;
                  end
                  OP_LDI, OP_STI: begin
                     bus.alu_a_sel    = ALU_A_PC;
                     bus.alu_b_sel    = ALU_B_SEXT;
                     bus.sext_sel     = SEXT_OFF9;
                     bus.alu_op       = ALU_ADD;
                     bus.mem_addr_sel = MEM_ADDR_ALU;
                     bus.store_ld     = 1'b1;
                     w_next           = S_EXEC2;
                  end
                  default: begin
                  end
               endcase
            end
            S_EXEC2: begin
               w_next           = S_FETCH;
               bus.mem_addr_sel = MEM_ADDR_STORE;
               if (w_op == OP_LDI) begin
                  bus.rf_w_sel  = RF_W_MEM;
                  bus.rf_w_addr = bus.ir[11:9];
                  bus.rf_w_en   = 1'b1;
                  bus.nzp_sel   = NZP_MEM;
                  bus.nzp_ld    = 1'b1;
               end else if (w_op == OP_STI) begin
                  bus.rf_r_addr_1 = bus.ir[11:9];
                  bus.mem_w_en    = 1'b1;
               end
            end
            S_HALT: begin
               bus.halted = 1'b1;
               w_next     = S_HALT;
            end
            default: begin
               w_next = S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: behavioural datapath driven by the controller,
// checked against an instruction-level LC3 reference model.
module tb_punc_control;

   logic clk = 1'b0;
   logic rst = 1'b1;

   punc_control_if bus();

   punc_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] m_mem [0:65535];
   logic [15:0] m_rf  [0:7];
   logic [15:0] m_pc;
   logic [15:0] m_ir;
   logic [15:0] m_st;
   logic [2:0]  m_nzp;

   assign bus.ir   = m_ir;
   assign bus.cc_n = m_nzp[2];
   assign bus.cc_z = m_nzp[1];
   assign bus.cc_p = m_nzp[0];

   wire [7:0] w_en = {bus.pc_clr, bus.pc_inc, bus.pc_ld, bus.ir_ld,
                      bus.mem_w_en, bus.store_ld, bus.rf_w_en, bus.nzp_ld};
   wire [29:0] w_rest = {bus.pc_inc, bus.pc_ld, bus.pc_data_sel,
                         bus.pc_add_sel, bus.ir_ld, bus.mem_addr_sel,
                         bus.mem_w_en, bus.store_ld, bus.rf_r_addr_0,
                         bus.rf_r_addr_1, bus.rf_w_addr, bus.rf_w_en,
                         bus.rf_w_sel, bus.sext_sel, bus.alu_a_sel,
                         bus.alu_b_sel, bus.alu_op, bus.nzp_sel,
                         bus.nzp_ld, bus.halted};
   wire [3:0] w_fetch = {bus.ir_ld, bus.pc_inc, bus.mem_addr_sel};

   int errors = 0;
   int checks = 0;
   int n_ir_ld = 0;
   int n_pc_ld = 0;
   int n_store = 0;

   logic [15:0] e_pc;
   logic [15:0] e_rf [0:7];
   logic [2:0]  e_nzp;
   int          e_cyc;
   logic        e_wr;
   logic [15:0] e_wa;
   logic [15:0] e_wd;

   function automatic logic [2:0] flg(input logic [15:0] v);
      if (v[15])         return 3'b100;
      else if (v == 0)   return 3'b010;
      else               return 3'b001;
   endfunction

   // one clock of the behavioural datapath, driven by current controls
   task automatic tick();
      logic [15:0] sx, r0, r1, a, b, alu, madr, mrd, padd, wd;
      logic c_clr, c_inc, c_pld, c_psel, c_ild, c_mw, c_sld, c_rw;
      logic c_nld, c_nsel;
      logic [2:0] c_wa;
      case (bus.sext_sel)
         2'b00:   sx = {{11{m_ir[4]}}, m_ir[4:0]};
         2'b01:   sx = {{10{m_ir[5]}}, m_ir[5:0]};
         2'b10:   sx = {{7{m_ir[8]}}, m_ir[8:0]};
         default: sx = {{5{m_ir[10]}}, m_ir[10:0]};
      endcase
      r0 = m_rf[bus.rf_r_addr_0];
      r1 = m_rf[bus.rf_r_addr_1];
      a  = bus.alu_a_sel ? r0 : m_pc;
      b  = bus.alu_b_sel ? sx : r1;
      case (bus.alu_op)
         2'b00:   alu = a + b;
         2'b01:   alu = a & b;
         2'b10:   alu = ~a;
         default: alu = a;
      endcase
      case (bus.mem_addr_sel)
         2'b00:   madr = m_pc;
         2'b01:   madr = alu;
         default: madr = m_st;
      endcase
      mrd  = m_mem[madr];
      padd = m_pc + (bus.pc_add_sel ? {{7{m_ir[8]}}, m_ir[8:0]}
                                    : {{5{m_ir[10]}}, m_ir[10:0]});
      case (bus.rf_w_sel)
         2'b00:   wd = m_pc;
         2'b01:   wd = mrd;
         default: wd = alu;
      endcase
      c_clr = bus.pc_clr;  c_inc = bus.pc_inc;  c_pld = bus.pc_ld;
      c_psel = bus.pc_data_sel;  c_ild = bus.ir_ld;  c_mw = bus.mem_w_en;
      c_sld = bus.store_ld;  c_rw = bus.rf_w_en;  c_wa = bus.rf_w_addr;
      c_nld = bus.nzp_ld;  c_nsel = bus.nzp_sel;
      if (c_ild) n_ir_ld++;
      if (c_pld) n_pc_ld++;
      if (c_sld) n_store++;
      @(posedge clk);
      #1;
      if (c_clr)      m_pc = 16'h0000;
      else if (c_pld) m_pc = c_psel ? r0 : padd;
      else if (c_inc) m_pc = m_pc + 16'd1;
      if (c_ild) m_ir = mrd;
      if (c_sld) m_st = mrd;
      if (c_mw)  m_mem[madr] = r1;
      if (c_rw)  m_rf[c_wa] = wd;
      if (c_nld) m_nzp = flg(c_nsel ? mrd : alu);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   // instruction-level LC3 semantics for the word at m_mem[m_pc]
   task automatic ref_exec();
      logic [15:0] ins, pc1, off9, off6, imm5, off11, v, sr1;
      ins   = m_mem[m_pc];
      pc1   = m_pc + 16'd1;
      off9  = {{7{ins[8]}}, ins[8:0]};
      off6  = {{10{ins[5]}}, ins[5:0]};
      imm5  = {{11{ins[4]}}, ins[4:0]};
      off11 = {{5{ins[10]}}, ins[10:0]};
      sr1   = m_rf[ins[8:6]];
      for (int i = 0; i < 8; i++) e_rf[i] = m_rf[i];
      e_pc  = pc1;
      e_nzp = m_nzp;
      e_cyc = 3;
      e_wr  = 1'b0;
      e_wa  = 16'h0;
      e_wd  = 16'h0;
      case (ins[15:12])
         4'd1: begin
            v = sr1 + (ins[5] ? imm5 : m_rf[ins[2:0]]);
            e_rf[ins[11:9]] = v;  e_nzp = flg(v);
         end
         4'd5: begin
            v = sr1 & (ins[5] ? imm5 : m_rf[ins[2:0]]);
            e_rf[ins[11:9]] = v;  e_nzp = flg(v);
         end
         4'd9: begin
            v = ~sr1;
            e_rf[ins[11:9]] = v;  e_nzp = flg(v);
         end
         4'd0: if ((ins[11:9] & m_nzp) != 3'b000) e_pc = pc1 + off9;
         4'd12: e_pc = sr1;
         4'd4: begin
            e_pc = ins[11] ? pc1 + off11 : sr1;
            e_rf[7] = pc1;
         end
         4'd2: begin
            v = m_mem[pc1 + off9];
            e_rf[ins[11:9]] = v;  e_nzp = flg(v);
         end
         4'd6: begin
            v = m_mem[sr1 + off6];
            e_rf[ins[11:9]] = v;  e_nzp = flg(v);
         end
         4'd3: begin
            e_wr = 1'b1;  e_wa = pc1 + off9;  e_wd = m_rf[ins[11:9]];
         end
         4'd7: begin
            e_wr = 1'b1;  e_wa = sr1 + off6;  e_wd = m_rf[ins[11:9]];
         end
         4'd14: e_rf[ins[11:9]] = pc1 + off9;
         4'd10: begin
            v = m_mem[m_mem[pc1 + off9]];
            e_rf[ins[11:9]] = v;  e_nzp = flg(v);  e_cyc = 4;
         end
         4'd11: begin
            e_wr = 1'b1;  e_wa = m_mem[pc1 + off9];
            e_wd = m_rf[ins[11:9]];  e_cyc = 4;
         end
         default: begin
         end
      endcase
   endtask

   task automatic test_reset();
      checks++;
      if (bus.pc_clr !== 1'b1) begin
         errors++;
         $display("FAIL reset_pc_clr: got %b want 1", bus.pc_clr);
      end
      checks++;
      if (w_rest !== 30'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", w_rest);
      end
      m_pc = 16'h1234;
      do_reset();
      checks++;
      if (m_pc !== 16'h0000) begin
         errors++;
         $display("FAIL reset_pc: got %h want 0000", m_pc);
      end
      checks++;
      if (w_fetch !== 4'b1100) begin
         errors++;
         $display("FAIL reset_fetch: got %b want 1100", w_fetch);
      end
   endtask

   task automatic test_sti_reset();
      int w0;
      do_reset();
      m_pc = 16'h0100;
      m_mem[16'h0100] = 16'hB5FF;
      m_mem[16'hB5FF] = 16'hAAAA;
      m_rf[2] = 16'h1234;
      run(3);
      checks++;
      if (bus.mem_w_en !== 1'b1) begin
         errors++;
         $display("FAIL sti_exec2_w_en: got %b want 1", bus.mem_w_en);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.pc_clr, bus.mem_w_en} !== 2'b10) begin
         errors++;
         $display("FAIL sti_rst_mask: got %b want 10",
                  {bus.pc_clr, bus.mem_w_en});
      end
      w0 = n_ir_ld;
      tick();
      checks++;
      if (m_mem[16'hB5FF] !== 16'hAAAA) begin
         errors++;
         $display("FAIL sti_no_write: got %h want aaaa", m_mem[16'hB5FF]);
      end
      checks++;
      if ({bus.pc_clr, w_rest} !== {1'b1, 30'h0}) begin
         errors++;
         $display("FAIL sti_rst_hold: got %b/%h want 1/0", bus.pc_clr, w_rest);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({m_pc, w_fetch} !== {16'h0000, 4'b1100}) begin
         errors++;
         $display("FAIL sti_after_rst: got %h/%b want 0000/1100", m_pc, w_fetch);
      end
   endtask

   task automatic test_add_imm();
      int f0;
      m_mem[16'h0000] = 16'h1265;
      m_rf[1] = 16'd3;
      do_reset();
      f0 = n_ir_ld;
      run(3);
      checks++;
      if ({m_rf[1], m_nzp, m_pc} !== {16'd8, 3'b001, 16'h0001}) begin
         errors++;
         $display("FAIL add_imm: got r1=%h nzp=%b pc=%h want 0008/001/0001",
                  m_rf[1], m_nzp, m_pc);
      end
      checks++;
      if ((n_ir_ld - f0) != 1 || w_fetch !== 4'b1100) begin
         errors++;
         $display("FAIL add_latency: got fetches=%0d next=%b want 1/1100",
                  n_ir_ld - f0, w_fetch);
      end
   endtask

   task automatic test_branch();
      int p0;
      do_reset();
      m_pc = 16'h0010;
      m_mem[16'h0010] = 16'h0404;
      m_nzp = 3'b010;
      run(3);
      checks++;
      if (m_pc !== 16'h0015) begin
         errors++;
         $display("FAIL br_taken: got %h want 0015", m_pc);
      end
      do_reset();
      m_pc = 16'h0010;
      m_nzp = 3'b001;
      p0 = n_pc_ld;
      run(3);
      checks++;
      if (m_pc !== 16'h0011 || n_pc_ld != p0) begin
         errors++;
         $display("FAIL br_not_taken: got pc=%h pc_ld=%0d want 0011/0",
                  m_pc, n_pc_ld - p0);
      end
   endtask

   task automatic test_ldi();
      int s0;
      do_reset();
      m_pc = 16'h0020;
      m_mem[16'h0020] = 16'hA602;
      m_mem[16'h0023] = 16'h0040;
      m_mem[16'h0040] = 16'h8000;
      m_nzp = 3'b010;
      s0 = n_store;
      run(3);
      checks++;
      if ((n_store - s0) != 1 || m_st !== 16'h0040) begin
         errors++;
         $display("FAIL ldi_store_ld: got n=%0d st=%h want 1/0040",
                  n_store - s0, m_st);
      end
      run(1);
      checks++;
      if ({m_rf[3], m_nzp, m_pc} !== {16'h8000, 3'b100, 16'h0021}) begin
         errors++;
         $display("FAIL ldi_result: got r3=%h nzp=%b pc=%h want 8000/100/0021",
                  m_rf[3], m_nzp, m_pc);
      end
      checks++;
      if (w_fetch !== 4'b1100) begin
         errors++;
         $display("FAIL ldi_latency: got %b want 1100", w_fetch);
      end
   endtask

   task automatic test_jsrr();
      do_reset();
      m_pc = 16'h0030;
      m_mem[16'h0030] = 16'h41C0;
      m_rf[7] = 16'h0050;
      run(3);
      checks++;
      if ({m_pc, m_rf[7]} !== {16'h0050, 16'h0031}) begin
         errors++;
         $display("FAIL jsrr_r7: got pc=%h r7=%h want 0050/0031", m_pc, m_rf[7]);
      end
   endtask

   task automatic test_halt();
      int bad;
      do_reset();
      m_pc = 16'h0040;
      m_mem[16'h0040] = 16'hF025;
      run(2);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if ({bus.halted, w_en} !== 9'b1_0000_0000) begin
            errors++;
            bad++;
            if (bad < 4)
               $display("FAIL halt_hold: cycle %0d got %b want 100000000",
                        i, {bus.halted, w_en});
         end
         tick();
      end
      do_reset();
      checks++;
      if ({m_pc, w_fetch, bus.halted} !== {16'h0000, 4'b1100, 1'b0}) begin
         errors++;
         $display("FAIL halt_reset: got pc=%h fetch=%b halted=%b want 0000/1100/0",
                  m_pc, w_fetch, bus.halted);
      end
   endtask

   task automatic test_random();
      logic [15:0] ins;
      logic        ok;
      int          f0;
      int          bad;
      for (int i = 0; i < 8; i++) m_rf[i] = 16'($urandom);
      do_reset();
      m_nzp = 3'b010;
      bad = 0;
      for (int k = 0; k < 300; k++) begin
         ins = 16'($urandom);
         if (ins[15:12] == 4'hF) ins[15:12] = 4'($urandom_range(0, 14));
         m_mem[m_pc] = ins;
         ref_exec();
         f0 = n_ir_ld;
         run(e_cyc);
         ok = 1'b1;
         for (int r = 0; r < 8; r++) if (m_rf[r] !== e_rf[r]) ok = 1'b0;
         checks++;
         if (!ok || m_pc !== e_pc || m_nzp !== e_nzp) begin
            errors++;
            bad++;
            if (bad < 6)
               $display("FAIL rand_arch: ins=%h got pc=%h nzp=%b want pc=%h nzp=%b regs_ok=%b",
                        ins, m_pc, m_nzp, e_pc, e_nzp, ok);
         end
         if (e_wr) begin
            checks++;
            if (m_mem[e_wa] !== e_wd) begin
               errors++;
               bad++;
               if (bad < 6)
                  $display("FAIL rand_store: ins=%h got mem[%h]=%h want %h",
                           ins, e_wa, m_mem[e_wa], e_wd);
            end
         end
         checks++;
         if ((n_ir_ld - f0) != 1 || w_fetch !== 4'b1100) begin
            errors++;
            bad++;
            if (bad < 6)
               $display("FAIL rand_latency: ins=%h got fetches=%0d next=%b want 1/1100",
                        ins, n_ir_ld - f0, w_fetch);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) m_mem[i] = 16'($urandom);
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_pc  = 16'h0000;
      m_ir  = 16'h0000;
      m_st  = 16'h0000;
      m_nzp = 3'b010;
      test_reset();
      test_sti_reset();
      test_add_imm();
      test_branch();
      test_ldi();
      test_jsrr();
      test_halt();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Multicycle control FSM for the PUnC LC3 processor. It sequences punc_datapath through fetch, decode and execute for every LC3 instruction.
- Combinational control outputs depend only on the current state, the IR contents and the condition flags. They drive the datapath's select, load and write-enable inputs.
- The controller instantiates no storage other than its state register. It sits beside the datapath inside the PUnC top level.

Parameters:
- none. All encodings are constants in punc_ctrl_pkg.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- ir  input  16  current instruction register contents from the datapath
- cc_n, cc_z, cc_p  input  1 each  condition flags from the datapath
- pc_clr  output  1  clear PC to 0x0000
- pc_inc  output  1  PC <- PC+1
- pc_ld  output  1  load PC from the pc_data_sel source
- pc_data_sel  output  1  0 = PC adder output, 1 = BaseR (rf_r_data_0)
- pc_add_sel  output  1  0 = PC+sext(off11), 1 = PC+sext(off9)
- ir_ld  output  1  IR <- mem_r_data
- mem_addr_sel  output  2  00 = PC, 01 = ALU result, 10 = store register
- mem_w_en  output  1  memory write enable
- store_ld  output  1  store register <- mem_r_data
- rf_r_addr_0, rf_r_addr_1, rf_w_addr  output  3 each  register file addresses
- rf_w_en  output  1  register file write enable
- rf_w_sel  output  2  00 = PC, 01 = mem_r_data, 10 = ALU result
- sext_sel  output  2  00 = imm5, 01 = off6, 10 = off9, 11 = off11
- alu_a_sel  output  1  0 = PC, 1 = rf_r_data_0
- alu_b_sel  output  1  0 = rf_r_data_1, 1 = sext output
- alu_op  output  2  00 = ADD, 01 = AND, 10 = NOT A, 11 = PASS A
- nzp_sel  output  1  0 = flags from ALU result, 1 = flags from mem_r_data
- nzp_ld  output  1  update N/Z/P
- halted  output  1  high in HALT

Behaviour:
- States: FETCH, DECODE, EXEC, EXEC2, HALT; 3-bit encoding.
- rst high at a clock edge: state <= FETCH. While rst is high, every output is 0 except pc_clr=1. This overrides any operation in progress, including EXEC2 of STI, so no memory or register write occurs.
- Default for any unlisted output in any state: 0.
- FETCH: mem_addr_sel=PC, ir_ld=1, pc_inc=1. Next state DECODE.
- DECODE: no enables asserted. Next state HALT if ir[15:12]=1111, otherwise EXEC.
- EXEC by opcode (PC already holds address+1):
  - ADD/AND (0001/0101): r0=ir[8:6], r1=ir[2:0], alu_b_sel=ir[5], sext_sel=imm5, rf_w_sel=ALU, w_addr=ir[11:9], rf_w_en=1, nzp_ld=1, nzp_sel=ALU.
  - NOT (1001): alu_op=NOT, r0=ir[8:6]; write and flag update as for ADD.
  - BR (0000): if (ir[11]&cc_n)|(ir[10]&cc_z)|(ir[9]&cc_p) then pc_ld=1, pc_data_sel=adder, pc_add_sel=off9. nzp=000 never branches.
  - JMP/RET (1100): pc_ld=1, pc_data_sel=BaseR, r0=ir[8:6].
  - JSR/JSRR (0100): rf_w_en=1, w_addr=7, rf_w_sel=PC, pc_ld=1. ir[11]=1 selects adder with off11; ir[11]=0 selects BaseR=ir[8:6]. Register reads return pre-write values, so JSRR R7 jumps to the old R7.
  - LD (0010): alu A=PC, B=sext off9, ADD, mem_addr_sel=ALU, rf_w_sel=MEM, rf_w_en=1, nzp_ld=1, nzp_sel=MEM.
  - LDR (0110): as LD but A=rf[ir[8:6]], sext off6.
  - ST (0011): address as LD, r1=ir[11:9], mem_w_en=1.
  - STR (0111): address as LDR, r1=ir[11:9], mem_w_en=1.
  - LEA (1110): A=PC, B=off9, ADD, rf_w_sel=ALU, rf_w_en=1. Flags unchanged.
  - LDI (1010) / STI (1011): PC+off9 address, store_ld=1. Next state EXEC2.
  - RTI (1000) and reserved (1101): no operation.
- EXEC2: mem_addr_sel=store.
  - LDI: rf_w_sel=MEM, rf_w_en=1, nzp_ld=1, nzp_sel=MEM.
  - STI: r1=ir[11:9], mem_w_en=1.
- EXEC and EXEC2 return to FETCH.
- Latency: 3 cycles per instruction; 4 for LDI/STI.
- HALT: halted=1, all enables 0. The state holds until rst.
- Every output is a pure function of (state, ir, cc). No output is registered.

Decomposition:
- punc_ctrl_pkg holds:
  - state encodings;
  - opcode constants: OP_BR, OP_ADD, OP_LD, OP_ST, OP_JSR, OP_AND, OP_LDR, OP_STR, OP_RTI, OP_NOT, OP_LDI, OP_STI, OP_JMP, OP_RES, OP_LEA, OP_TRAP;
  - the mux-select and alu_op encodings listed above.
- punc_datapath imports the same package.
- Optional sub-module punc_br_eval: combinational branch-taken evaluation from ir[11:9] and the flags.
- The FSM stays in one module.

Test Plan:
- Setup: behavioural memory and register file model driven by the control outputs.
- Reset mid-execution: assert rst during EXEC2 of STI 0xB5FF (STI R2 at PC-1) -> mem_w_en stays 0; next cycle state=FETCH and pc_clr=1 while rst is high.
- ADD immediate: mem[0]=0x1265 (ADD R1,R1,#5), R1=3 -> after 3 cycles R1=8, NZP=001, PC=1, one FETCH/DECODE/EXEC each.
- Branch taken and not taken: BRz +4 (0x0404) at PC=0x0010.
  - Z=1 -> PC=0x0015.
  - Z=0 -> PC=0x0011; pc_ld never asserted.
- Indirect load: LDI R3,#2 (0x3602 → 0xA602) at 0x0020, mem[0x0023]=0x0040, mem[0x0040]=0x8000 -> 4 cycles, store_ld in EXEC, R3=0x8000, NZP=100.
- JSRR through R7: R7=0x0050, JSRR R7 (0x41C0) at 0x0030 -> PC=0x0050, R7=0x0031.
- HALT: 0xF025 -> DECODE→HALT; halted=1 for 20 further cycles with no enables; rst returns to FETCH and PC=0.
